// File: rtl/imem_loader.sv
// Boot loader: streams length, payload and checksum into instruction memory,
// optionally zero-fills the remainder, and holds the CPU until a good image lands.
module imem_loader #(
    parameter bit FILL_ZERO = 1'b1,
    parameter bit CHECK_SUM = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_in_valid,
    input  logic [7:0] i_in_data,
    output logic       o_in_ready,
    output logic       o_imem_we,
    output logic [7:0] o_imem_addr,
    output logic [7:0] o_imem_data,
    output logic       o_cpu_hold,
    output logic       o_done,
    output logic       o_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CSUM, S_FILL, S_DONE, S_ERR
    } state_t;

    state_t     r_state, w_next;
    logic [7:0] r_cnt, w_cnt;
    logic [7:0] r_last, w_last;
    logic [7:0] r_sum, w_sum;
    logic       r_we, w_we;
    logic [7:0] r_addr, w_addr;
    logic [7:0] r_data, w_data;
    logic       r_ready, r_done, r_error, r_hold;
    logic       w_xfer;

    assign w_xfer = i_in_valid && r_ready;

    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        w_last = r_last;
        w_sum  = r_sum;
        w_we   = 1'b0;
        w_addr = r_addr;
        w_data = r_data;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) begin
                    w_next = S_LEN;
                    w_cnt  = 8'd0;
                    w_sum  = 8'd0;
                end
            end
            S_LEN: begin
                // r_last holds N-1, so a length byte of 0 naturally means 256
                if (w_xfer) begin
                    w_last = i_in_data - 8'd1;
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    w_we   = 1'b1;
                    w_addr = r_cnt;
                    w_data = i_in_data;
                    w_sum  = r_sum + i_in_data;
                    w_cnt  = r_cnt + 8'd1;
                    if (r_cnt == r_last)
                        w_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_xfer) begin
                    if (CHECK_SUM && (i_in_data != r_sum)) begin
                        w_next = S_ERR;
                    end else if (FILL_ZERO && (r_last != 8'hFF)) begin
                        // first fill write issues with the checksum accept
                        w_next = S_FILL;
                        w_we   = 1'b1;
                        w_addr = r_cnt;
                        w_data = 8'h00;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_FILL: begin
                if (r_addr == 8'hFF) begin
                    w_next = S_DONE;
                end else begin
                    w_we   = 1'b1;
                    w_addr = r_addr + 8'd1;
                    w_data = 8'h00;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_last  <= 8'd0;
            r_sum   <= 8'd0;
            r_we    <= 1'b0;
            r_addr  <= 8'd0;
            r_data  <= 8'd0;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_hold  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_last  <= w_last;
            r_sum   <= w_sum;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_ready <= (w_next == S_LEN) || (w_next == S_DATA)
                    || (w_next == S_CSUM);
            r_done  <= (w_next == S_DONE);
            r_error <= (w_next == S_ERR);
            r_hold  <= (w_next != S_DONE);
        end
    end

    assign o_in_ready  = r_ready;
    assign o_imem_we   = r_we;
    assign o_imem_addr = r_addr;
    assign o_imem_data = r_data;
    assign o_done      = r_done;
    assign o_error     = r_error;
    assign o_cpu_hold  = r_hold;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed loads with random payloads and gaps,
// checked against a write-list / memory-image model.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst, start, in_valid;
    logic [7:0] in_data;
    logic       in_ready, imem_we, cpu_hold, done, error;
    logic [7:0] imem_addr, imem_data;

    imem_loader dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_in_valid(in_valid), .i_in_data(in_data),
        .o_in_ready(in_ready), .o_imem_we(imem_we),
        .o_imem_addr(imem_addr), .o_imem_data(imem_data),
        .o_cpu_hold(cpu_hold), .o_done(done), .o_error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         tmo = 0;
    int         rdy_hi = 0;
    bit         watch_rdy = 0;
    int         done_cyc = -1;
    int         err_cyc = -1;
    logic       prev_done = 1'b0;
    logic       prev_err = 1'b0;
    wr_t        wq[$];
    logic [7:0] mem[256];
    logic [7:0] exp_mem[256];
    logic [7:0] pl[$];
    int         acc[256];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        wr_t e;
        if (imem_we === 1'b1) begin
            e.c = cyc;
            e.a = imem_addr;
            e.d = imem_data;
            wq.push_back(e);
            mem[imem_addr] = imem_data;
        end
        if (done && !prev_done) done_cyc = cyc;
        if (error && !prev_err) err_cyc = cyc;
        prev_done = done;
        prev_err  = error;
        if (watch_rdy && in_ready) rdy_hi++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap, output int at);
        int w;
        while (gap > 0 && $urandom_range(99) < gap) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!in_ready) tmo++;
        tick();
        at = cyc;
        in_valid = 1'b0;
    endtask

    task automatic load(input string tag, input bit bad, input int gap,
                        input bit poke);
        int         n, ec, la, w, mism, tmis, ed;
        bit         good;
        logic [7:0] s;
        wr_t        ew[$];
        wr_t        e;
        n = pl.size();
        good = !bad;
        wq.delete();
        tmo = 0;
        done_cyc = -1;
        err_cyc = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_ready_len"}, in_ready, 1);
        send(n[7:0], gap, la);
        s = 8'd0;
        foreach (pl[k]) begin
            if (poke && k == 1) start = 1'b1;
            send(pl[k], gap, acc[k]);
            start = 1'b0;
            s += pl[k];
        end
        if (bad) s ^= 8'h01;
        send(s, gap, ec);
        rdy_hi = 0;
        watch_rdy = 1;
        if (poke) begin
            in_valid = 1'b1;
            in_data  = 8'h77;
            start    = 1'b1;
            tick();
            start = 1'b0;
        end
        w = 0;
        while (!done && !error && w < 400) begin
            tick();
            w++;
        end
        in_valid = 1'b0;
        watch_rdy = 0;
        check({tag, "_timeout"}, (w >= 400 || tmo != 0), 0);
        // reference: payload to 0..N-1, then zeros to N..255 if good
        for (int k = 0; k < n; k++) begin
            e.c = acc[k];
            e.a = k[7:0];
            e.d = pl[k];
            ew.push_back(e);
        end
        if (good) begin
            for (int j = 0; j < 256 - n; j++) begin
                e.c = ec + j;
                e.a = 8'(n + j);
                e.d = 8'h00;
                ew.push_back(e);
            end
        end
        foreach (ew[i]) exp_mem[ew[i].a] = ew[i].d;
        check({tag, "_nwrites"}, wq.size(), ew.size());
        mism = 0;
        tmis = 0;
        for (int i = 0; i < ew.size() && i < wq.size(); i++) begin
            if (wq[i].a !== ew[i].a || wq[i].d !== ew[i].d) mism++;
            if (wq[i].c != ew[i].c) tmis++;
        end
        check({tag, "_wdata"}, mism, 0);
        check({tag, "_wtime"}, tmis, 0);
        mism = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== exp_mem[i]) mism++;
        check({tag, "_image"}, mism, 0);
        check({tag, "_done"}, done, good);
        check({tag, "_error"}, error, !good);
        check({tag, "_hold"}, cpu_hold, !good);
        check({tag, "_rdy_after"}, rdy_hi, 0);
        if (good) begin
            ed = (n < 256) ? ec + 256 - n : ec;
            check({tag, "_done_cyc"}, done_cyc, ed);
        end else begin
            check({tag, "_err_cyc"}, err_cyc, ec);
        end
    endtask

    initial begin
        int a0, a1, len;
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'hA5;
            exp_mem[i] = 8'hA5;
        end
        tick();
        tick();
        check("rst_outs",
              {in_ready, imem_we, imem_addr, imem_data, done, error, cpu_hold},
              {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1});
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h55;
        tick();
        tick();
        check("idle_ready", in_ready, 0);
        check("idle_nowrite", wq.size(), 0);
        in_valid = 1'b0;

        pl = '{8'h12, 8'h34, 8'h56};
        load("t1", 0, 0, 0);

        pl = '{8'h10, 8'h20};
        load("t2", 1, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_restart_err", error, 0);
        check("t2_restart_rdy", in_ready, 1);

        pl.delete();
        for (int i = 0; i < 256; i++) pl.push_back(i[7:0]);
        load("t3", 0, 0, 0);

        pl = '{8'h12, 8'h34, 8'h56};
        load("t4", 0, 40, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        send(8'd5, 0, a0);
        send(8'hC1, 0, a0);
        send(8'hC2, 0, a1);
        exp_mem[0] = 8'hC1;
        exp_mem[1] = 8'hC2;
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hC3;
        tick();
        check("t5_rst_outs",
              {in_ready, imem_we, imem_addr, imem_data, done, error, cpu_hold},
              {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1});
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        pl.delete();
        len = $urandom_range(20, 1);
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
        load("t5", 0, 0, 0);

        pl.delete();
        for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
        load("t6", 0, 0, 1);

        for (int r = 0; r < 3; r++) begin
            pl.delete();
            len = $urandom_range(60, 1);
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            load("rnd", ($urandom_range(3) == 0), 30, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
